// File: rtl/gestor_estados_mascota.sv
// rtl/gestor_estados_mascota.sv - pet state sequencer with second timebase, test mode and death timeout
module gestor_estados_mascota #(
    parameter int TICKS_SEG = 50_000_000,
    parameter int TEST_DIV  = 10,
    parameter int T_MUERTE  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       test,
    input  logic [1:0] nivel_animo,
    input  logic [1:0] nivel_energia,
    input  logic [1:0] nivel_descanso,
    input  logic [1:0] nivel_medicina,
    output logic [2:0] estado,
    output logic       activo_comida,
    output logic       activo_medicina,
    output logic       modo_test,
    output logic       tick_seg,
    output logic       muerto
);

    typedef enum logic [2:0] {
        IDEAL      = 3'd0,
        ENFERMO    = 3'd1,
        HAMBRIENTO = 3'd2,
        CANSADO    = 3'd3,
        TRISTE     = 3'd4,
        MUERTO     = 3'd5
    } estado_t;

    localparam int P_TEST_RAW = TICKS_SEG / TEST_DIV;
    localparam int P_TEST     = (P_TEST_RAW < 1) ? 1 : P_TEST_RAW;
    localparam int CW         = (TICKS_SEG > 1) ? $clog2(TICKS_SEG) : 1;
    localparam int DW         = (T_MUERTE > 0) ? $clog2(T_MUERTE + 1) : 1;
    localparam logic [CW-1:0] ULT_NORMAL = CW'(TICKS_SEG - 1);
    localparam logic [CW-1:0] ULT_TEST   = CW'(P_TEST - 1);
    localparam logic [DW-1:0] MUERTE_MAX = DW'(T_MUERTE);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [DW-1:0] muerte_q, muerte_d;
    logic          modo_test_q, modo_test_d;
    logic          tick_q, tick_d;
    logic          comida_q, comida_d;
    logic          medicina_q, medicina_d;
    logic          muerto_q, muerto_d;

    logic          toggle;
    logic          algun_cero;
    logic [CW-1:0] ultimo;
    logic [1:0]    nivel_propio;
    estado_t       necesidad;

    always_comb begin
        toggle      = test & (estado_q != MUERTO);
        ultimo      = modo_test_q ? ULT_TEST : ULT_NORMAL;
        presc_d     = presc_q + CW'(1);
        tick_d      = 1'b0;
        modo_test_d = modo_test_q;
        // A toggle restarts the timebase and swallows a coincident terminal count.
        if (toggle) begin
            modo_test_d = ~modo_test_q;
            presc_d     = '0;
        end else if (presc_q >= ultimo) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
    end

    always_comb begin
        algun_cero = (nivel_animo == 2'd0) | (nivel_energia == 2'd0) |
                     (nivel_descanso == 2'd0) | (nivel_medicina == 2'd0);
        muerte_d = muerte_q;
        if (!algun_cero) begin
            muerte_d = '0;
        end else if (tick_q && (muerte_q != MUERTE_MAX)) begin
            muerte_d = muerte_q + DW'(1);
        end
    end

    always_comb begin
        if (nivel_medicina <= 2'd1) begin
            necesidad = ENFERMO;
        end else if (nivel_energia <= 2'd1) begin
            necesidad = HAMBRIENTO;
        end else if (nivel_descanso <= 2'd1) begin
            necesidad = CANSADO;
        end else if (nivel_animo <= 2'd1) begin
            necesidad = TRISTE;
        end else begin
            necesidad = IDEAL;
        end

        nivel_propio = 2'd0;
        case (estado_q)
            ENFERMO:    nivel_propio = nivel_medicina;
            HAMBRIENTO: nivel_propio = nivel_energia;
            CANSADO:    nivel_propio = nivel_descanso;
            TRISTE:     nivel_propio = nivel_animo;
            default:    nivel_propio = 2'd0;
        endcase

        estado_d = estado_q;
        if (muerte_q == MUERTE_MAX) begin
            estado_d = MUERTO;
        end else begin
            case (estado_q)
                IDEAL: estado_d = necesidad;
                ENFERMO, HAMBRIENTO, CANSADO, TRISTE: begin
                    // Lower codes are higher priority; leaving needs the own level back at full.
                    if ((necesidad != IDEAL) && (necesidad < estado_q)) begin
                        estado_d = necesidad;
                    end else if (nivel_propio == 2'd3) begin
                        estado_d = necesidad;
                    end
                end
                MUERTO:  estado_d = MUERTO;
                default: estado_d = IDEAL;
            endcase
        end

        comida_d   = (estado_d == HAMBRIENTO);
        medicina_d = (estado_d == ENFERMO);
        muerto_d   = (estado_d == MUERTO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= IDEAL;
            presc_q     <= '0;
            muerte_q    <= '0;
            modo_test_q <= 1'b0;
            tick_q      <= 1'b0;
            comida_q    <= 1'b0;
            medicina_q  <= 1'b0;
            muerto_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            presc_q     <= presc_d;
            muerte_q    <= muerte_d;
            modo_test_q <= modo_test_d;
            tick_q      <= tick_d;
            comida_q    <= comida_d;
            medicina_q  <= medicina_d;
            muerto_q    <= muerto_d;
        end
    end

    assign estado          = estado_q;
    assign activo_comida   = comida_q;
    assign activo_medicina = medicina_q;
    assign modo_test       = modo_test_q;
    assign tick_seg        = tick_q;
    assign muerto          = muerto_q;

endmodule

// File: doc/gestor_estados_mascota.md
Name: gestor_estados_mascota

Overview:
Central sequencer for the four mode channels (Animo, Energia, Descanso, Medicina). It watches the four 2-bit levels and keeps a registered pet state with priority and hysteresis. It grants the feeding and medicine channels mutually exclusive enables, which drive the Activo_Comida and Activo_Medicina inputs of the mode block. It also owns the one-second timebase, the test-mode acceleration and the death timeout.

Parameters:
TICKS_SEG, 50_000_000, clk cycles per second tick in normal mode.
TEST_DIV, 10, tick-rate multiplier in test mode (period = TICKS_SEG/TEST_DIV cycles, integer divide).
T_MUERTE, 10, consecutive second ticks with any level at 0 before the state becomes MUERTO.

Ports:
clk  in  1  system clock; all logic rising-edge.
reset  in  1  asynchronous, active-low reset.
test  in  1  debounced one-cycle pulse; toggles test mode.
nivel_animo  in  2  Animo level, 0 = empty, 3 = full.
nivel_energia  in  2  Energia level.
nivel_descanso  in  2  Descanso level.
nivel_medicina  in  2  Medicina level.
estado  out  3  pet state code (encodings below).
activo_comida  out  1  enable for the Energia channel.
activo_medicina  out  1  enable for the Medicina channel.
modo_test  out  1  1 while test mode is active.
tick_seg  out  1  one-cycle pulse each second (normal or accelerated).
muerto  out  1  1 while estado is MUERTO.

Behaviour:
- Reset (reset = 0, asynchronous) forces the following; all outputs are registered:
  - estado = IDEAL, activo_comida = 0, activo_medicina = 0;
  - modo_test = 0, tick_seg = 0, muerto = 0;
  - prescaler = 0, death counter = 0.
- State encodings: IDEAL = 0, ENFERMO = 1, HAMBRIENTO = 2, CANSADO = 3, TRISTE = 4, MUERTO = 5.
  - Codes 6 and 7 are illegal and return to IDEAL on the next clk.
- Prescaler:
  - Counts 0 up to P-1, where P = TICKS_SEG in normal mode and TICKS_SEG/TEST_DIV in test mode.
  - At P-1 it wraps to 0 and tick_seg = 1 for exactly one cycle.
- Test toggle:
  - A test pulse toggles modo_test on the next edge and clears the prescaler to 0.
  - If a test pulse coincides with the terminal count, the toggle wins: no tick_seg that cycle.
  - test is ignored while estado = MUERTO.
- Need set (evaluated every cycle, priority high to low):
  - medicina ≤ 1 gives ENFERMO;
  - energia ≤ 1 gives HAMBRIENTO;
  - descanso ≤ 1 gives CANSADO;
  - animo ≤ 1 gives TRISTE.
- Transitions from IDEAL: go to the highest-priority active need; stay in IDEAL if there is none.
- Transitions from a need state X:
  - Preemption: if a need with higher priority than X is active, move to it on the next edge.
  - Exit with hysteresis: leave X only when X's own level equals 3.
    - Then move to the highest-priority remaining need, or to IDEAL if there is none.
  - A lower-priority need never preempts X.
- Latency: estado updates one clk after the level change that causes it.
- Death counter:
  - Advances by 1 on each tick_seg while any level = 0.
  - Clears to 0 on any cycle in which no level is 0.
  - Saturates at T_MUERTE.
- MUERTO:
  - Entered on the edge after the counter reaches T_MUERTE; this overrides all other transitions.
  - Absorbing: only reset exits it.
  - In MUERTO: muerto = 1, both enables = 0, modo_test frozen, tick_seg still pulses.
- Enables (registered from the next state, so they change together with estado):
  - activo_comida = 1 iff estado = HAMBRIENTO;
  - activo_medicina = 1 iff estado = ENFERMO;
  - the two are never high in the same cycle.
- Reset mid-count or mid-state: the same asynchronous clear; no pulse is held over.

Test Plan:
Bench parameters: TICKS_SEG = 10, TEST_DIV = 5, T_MUERTE = 3.
1. Release reset with all levels = 3 and run 25 clk -> estado = 0, enables = 0; tick_seg pulses at cycles 10 and 20 after release; muerto = 0.
2. test pulse -> modo_test = 1, tick_seg every 2 clk. Pulse test again on a terminal-count cycle -> that tick is suppressed, modo_test = 0, next tick 10 clk later.
3. energia = 1 -> estado = 2 and activo_comida = 1 one clk later. Then medicina = 1 -> estado = 1, activo_medicina = 1, activo_comida = 0 in the same cycle.
4. From HAMBRIENTO raise energia to 2 -> stays 2. Raise it to 3 -> IDEAL. Sweep descanso = 1, then animo = 1 -> descanso need gives estado = 3; animo alone never preempts it.
5. animo = 0 held for 3 ticks -> estado = 5, muerto = 1, both enables 0. Later level changes and test pulses -> no change. Assert reset = 0 -> estado = 0.
6. Death race: level at 0 for 2 ticks, then restored to 1 before the 3rd tick -> death counter clears, no MUERTO; a later 0 needs a full 3 more ticks.
